// File: rtl/rvfi_replay_driver_pkg.sv
// Default configuration and RVFI record layout for the replay driver.
// Integrators pass their own core config and record type as parameters.
package rvfi_replay_driver_pkg;

   typedef struct packed {
      logic [31:0] NrCommitPorts;
   } cva6_cfg_t;

   localparam cva6_cfg_t cva6_cfg_empty = '{NrCommitPorts: 32'd2};

   typedef struct packed {
      logic        valid;
      logic [63:0] order;
      logic [31:0] insn;
      logic        trap;
      logic [63:0] cause;
      logic        halt;
      logic        intr;
      logic [1:0]  mode;
      logic [63:0] pc_rdata;
      logic [63:0] pc_wdata;
   } rvfi_instr_default_t;

endpackage

// File: rtl/rvfi_replay_driver_fifo.sv
// Replay FIFO: one push per cycle, up to NPOP in-order pops, a 'last' flag per entry.
// The head window exposes the NPOP oldest entries so the caller can pack a commit bus.
module rvfi_replay_fifo #(
   parameter int unsigned DEPTH   = 8,
   parameter int unsigned NPOP    = 2,
   parameter type         entry_t = logic
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         flush_i,
   input  logic                         push_i,
   input  entry_t                       push_data_i,
   input  logic                         push_last_i,
   input  logic [$clog2(NPOP+1)-1:0]    pop_cnt_i,
   output entry_t                       head_o [NPOP],
   output logic [NPOP-1:0]              head_last_o,
   output logic [$clog2(DEPTH+1)-1:0]   count_o
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   entry_t           mem_q [DEPTH];
   entry_t           mem_d [DEPTH];
   logic [DEPTH-1:0] last_q, last_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;

   always_comb begin
      mem_d    = mem_q;
      last_d   = last_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_i) begin
            mem_d[wr_ptr_q]  = push_data_i;
            last_d[wr_ptr_q] = push_last_i;
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
         end
         // DEPTH is a power of two, so pointer overflow is the wrap.
         rd_ptr_d = rd_ptr_q + PTR_W'(pop_cnt_i);
         count_d  = count_q + CNT_W'(push_i) - CNT_W'(pop_cnt_i);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Payload needs no reset: an entry is only visible below count_q.
   always_ff @(posedge clk_i) begin
      mem_q  <= mem_d;
      last_q <= last_d;
   end

   for (genvar gi = 0; gi < NPOP; gi++) begin : g_head
      logic [PTR_W-1:0] idx;
      assign idx             = rd_ptr_q + PTR_W'(gi);
      assign head_o[gi]      = mem_q[idx];
      assign head_last_o[gi] = last_q[idx];
   end

   assign count_o = count_q;

endmodule

// File: rtl/rvfi_replay_driver.sv
// Replays recorded RVFI retirements onto a multi-port commit bus, stopping after
// the record flagged 'last' until the trace is cleared.
module rvfi_replay_driver
   import rvfi_replay_driver_pkg::*;
#(
   parameter cva6_cfg_t   CVA6Cfg      = cva6_cfg_empty,
   parameter type         rvfi_instr_t = rvfi_instr_default_t,
   parameter int unsigned DEPTH        = 8
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        rec_valid_i,
   output logic        rec_ready_o,
   input  rvfi_instr_t rec_i,
   input  logic        rec_last_i,
   input  logic        start_i,
   input  logic        stall_i,
   input  logic        clear_i,
   output rvfi_instr_t rvfi_o [CVA6Cfg.NrCommitPorts],
   output logic        done_o,
   output logic [31:0] issued_o
);
   localparam int          NRET  = int'(CVA6Cfg.NrCommitPorts);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam int unsigned POP_W = $clog2(NRET + 1);

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_e;

   state_e           state_q, state_d;
   rvfi_instr_t      rvfi_q [NRET];
   rvfi_instr_t      rvfi_d [NRET];
   logic [31:0]      issued_q, issued_d;
   rvfi_instr_t      head [NRET];
   logic [NRET-1:0]  head_last;
   logic [CNT_W-1:0] fifo_count;
   logic [POP_W-1:0] pop_cnt;
   logic             push, flush, hit_last;

   rvfi_replay_fifo #(
      .DEPTH   (DEPTH),
      .NPOP    (NRET),
      .entry_t (rvfi_instr_t)
   ) u_fifo (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .flush_i     (flush),
      .push_i      (push),
      .push_data_i (rec_i),
      .push_last_i (rec_last_i),
      .pop_cnt_i   (pop_cnt),
      .head_o      (head),
      .head_last_o (head_last),
      .count_o     (fifo_count)
   );

   // Ready looks only at registered count, so a same-cycle pop never raises it.
   assign rec_ready_o = (state_q != ST_DONE) && (fifo_count < CNT_W'(DEPTH));

   always_comb begin
      state_d  = state_q;
      pop_cnt  = '0;
      hit_last = 1'b0;
      issued_d = issued_q;
      push     = rec_valid_i && rec_ready_o;
      flush    = 1'b0;
      for (int i = 0; i < NRET; i++) rvfi_d[i] = '0;

      if (state_q == ST_RUN && !stall_i) begin
         // Fill ports oldest-first; a 'last' entry closes the packet.
         for (int i = 0; i < NRET; i++) begin
            if (!hit_last && (CNT_W'(i) < fifo_count)) begin
               rvfi_d[i] = head[i];
               pop_cnt   = pop_cnt + POP_W'(1);
               issued_d  = issued_d + 32'(head[i].valid);
               hit_last  = head_last[i];
            end
         end
      end

      unique case (state_q)
         ST_IDLE: if (start_i)  state_d = ST_RUN;
         ST_RUN:  if (hit_last) state_d = ST_DONE;
         ST_DONE: if (clear_i) begin
            state_d = ST_IDLE;
            flush   = 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= ST_IDLE;
         issued_q <= '0;
         for (int i = 0; i < NRET; i++) rvfi_q[i] <= '0;
      end else begin
         state_q  <= state_d;
         issued_q <= issued_d;
         rvfi_q   <= rvfi_d;
      end
   end

   for (genvar gi = 0; gi < NRET; gi++) begin : g_out
      assign rvfi_o[gi] = rvfi_q[gi];
   end

   assign done_o   = (state_q == ST_DONE);
   assign issued_o = issued_q;

endmodule
